// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: redirect input, ROM port and decode handshake.
// master = fetch_queue side, slave = core/ROM side.
interface fetch_queue_if #(
   parameter int ADDR_W = 6
);
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_douta;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [31:0]       inst_pc;

   modport master (
      input  redirect_valid, redirect_pc, rom_douta, inst_ready,
      output rom_en, rom_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, rom_douta, inst_ready,
      input  rom_en, rom_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// RV32I fetch front end: PC, sync-ROM request and DEPTH-entry prefetch queue.
// Redirect flushes the queue and restarts fetch at the new PC.
module fetch_queue #(
   parameter int          ADDR_W   = 6,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clka,
   input  logic          rst_n,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t      mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0] fetch_pc;
   logic [31:0] inflight_pc;
   logic        inflight;

   logic        pop;
   logic        push;
   logic        issue;
   logic [CW:0] occ;

   assign bus.inst_valid = (count != '0) & ~bus.redirect_valid;
   assign pop  = bus.inst_valid & bus.inst_ready;
   assign push = inflight & ~bus.redirect_valid;

   // Credit: queued + in flight, after this cycle's pop, must leave room.
   assign occ = {1'b0, count}
              + {{CW{1'b0}}, inflight}
              - {{CW{1'b0}}, pop};
   assign issue = rst_n & ~bus.redirect_valid & (occ < DEPTH_C);

   assign bus.rom_en   = issue;
   assign bus.rom_addr = fetch_pc[ADDR_W+1:2];
   assign bus.inst     = mem[rd_ptr].inst;
   assign bus.inst_pc  = mem[rd_ptr].pc;

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.redirect_valid) begin
         fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (push) begin
            mem[wr_ptr] <= '{pc: inflight_pc, inst: bus.rom_douta};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed cycle table, reset pulse, random stream
// checked against an in-order PC stream model and an occupancy bound.
module tb_fetch_queue;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 4;

   logic clka;
   logic rst_n;
   int   tests;
   int   fails;
   int   outstanding;

   fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

   fetch_queue #(
      .ADDR_W(ADDR_W),
      .DEPTH(DEPTH),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clka(clka),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   // ROM word n holds n
   always_ff @(posedge clka) begin
      if (bus.rom_en) bus.rom_douta <= 32'(bus.rom_addr);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issued-but-not-consumed words may never exceed the queue depth
   always @(negedge clka or negedge rst_n) begin
      if (!rst_n) begin
         outstanding = 0;
      end else if (!clka) begin
         if (bus.redirect_valid) outstanding = 0;
         else outstanding += int'(bus.rom_en)
                           - int'(bus.inst_valid & bus.inst_ready);
         tests++;
         assert (outstanding >= 0 && outstanding <= DEPTH)
         else begin
            fails++;
            $display("FAIL overflow: outstanding %0d limit %0d",
                     outstanding, DEPTH);
         end
      end
   end

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        en;
      logic [5:0]  addr;
   } vec_t;

   function automatic vec_t mk(logic r, logic d, logic [31:0] rp,
                               logic v, logic [31:0] p, logic [31:0] n,
                               logic e, logic [5:0] a);
      vec_t t;
      t.ready = r; t.redir = d; t.rpc = rp;
      t.valid = v; t.pc = p; t.ins = n;
      t.en = e; t.addr = a;
      return t;
   endfunction

   vec_t tbl [28];

   initial begin
      logic [31:0] exp_pc;
      int idle;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;

      // stall from reset, drain, redirects (incl. misaligned and wrap)
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 1);
      tbl[2]  = mk(0, 0, 0, 1, 0, 0, 1, 2);
      tbl[3]  = mk(0, 0, 0, 1, 0, 0, 1, 3);
      for (int i = 4; i < 10; i++) tbl[i] = mk(0, 0, 0, 1, 0, 0, 0, 0);
      tbl[10] = mk(1, 0, 0, 1, 32'h0, 0, 1, 4);
      tbl[11] = mk(1, 0, 0, 1, 32'h4, 1, 1, 5);
      tbl[12] = mk(1, 0, 0, 1, 32'h8, 2, 1, 6);
      tbl[13] = mk(1, 1, 32'h40, 0, 0, 0, 0, 0);
      tbl[14] = mk(1, 0, 0, 0, 0, 0, 1, 16);
      tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 17);
      tbl[16] = mk(1, 0, 0, 1, 32'h40, 16, 1, 18);
      tbl[17] = mk(1, 0, 0, 1, 32'h44, 17, 1, 19);
      tbl[18] = mk(1, 1, 32'h13, 0, 0, 0, 0, 0);
      tbl[19] = mk(1, 0, 0, 0, 0, 0, 1, 4);
      tbl[20] = mk(1, 0, 0, 0, 0, 0, 1, 5);
      tbl[21] = mk(1, 0, 0, 1, 32'h10, 4, 1, 6);
      tbl[22] = mk(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      tbl[23] = mk(1, 0, 0, 0, 0, 0, 1, 63);
      tbl[24] = mk(1, 0, 0, 0, 0, 0, 1, 0);
      tbl[25] = mk(1, 0, 0, 1, 32'hFFFF_FFFC, 63, 1, 1);
      tbl[26] = mk(1, 0, 0, 1, 32'h0, 0, 1, 2);
      tbl[27] = mk(1, 0, 0, 1, 32'h4, 1, 1, 3);

      repeat (3) @(posedge clka);
      @(negedge clka);
      chk("rst_valid", 32'(bus.inst_valid), 0);
      chk("rst_inst", bus.inst, 0);
      chk("rst_pc", bus.inst_pc, 0);
      chk("rst_en", 32'(bus.rom_en), 0);
      @(posedge clka); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         bus.inst_ready = tbl[i].ready;
         bus.redirect_valid = tbl[i].redir;
         bus.redirect_pc = tbl[i].rpc;
         @(negedge clka);
         chk($sformatf("row%0d_valid", i), 32'(bus.inst_valid),
             32'(tbl[i].valid));
         chk($sformatf("row%0d_en", i), 32'(bus.rom_en), 32'(tbl[i].en));
         if (tbl[i].en)
            chk($sformatf("row%0d_addr", i), 32'(bus.rom_addr),
                32'(tbl[i].addr));
         if (tbl[i].valid) begin
            chk($sformatf("row%0d_pc", i), bus.inst_pc, tbl[i].pc);
            chk($sformatf("row%0d_inst", i), bus.inst, tbl[i].ins);
         end
         @(posedge clka); #1;
      end

      // partial-cycle reset pulse mid-stream
      bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("pulse_valid", 32'(bus.inst_valid), 0);
      chk("pulse_inst", bus.inst, 0);
      chk("pulse_pc", bus.inst_pc, 0);
      chk("pulse_en", 32'(bus.rom_en), 0);
      #1;
      rst_n = 1'b1;
      @(negedge clka);
      chk("rel0_en", 32'(bus.rom_en), 1);
      chk("rel0_addr", 32'(bus.rom_addr), 0);
      chk("rel0_valid", 32'(bus.inst_valid), 0);
      @(posedge clka); #1;
      @(negedge clka);
      chk("rel1_valid", 32'(bus.inst_valid), 0);
      @(posedge clka); #1;
      @(negedge clka);
      chk("rel2_valid", 32'(bus.inst_valid), 1);
      chk("rel2_pc", bus.inst_pc, 0);
      chk("rel2_inst", bus.inst, 0);
      @(posedge clka); #1;

      // random stream: accepted PCs must run in order from each redirect
      exp_pc = '0;
      idle = 0;
      for (int c = 0; c < 3000; c++) begin
         bus.inst_ready = ($urandom_range(0, 9) < 7);
         bus.redirect_valid = (c == 0) || ($urandom_range(0, 99) < 6);
         bus.redirect_pc = $urandom();
         if ($urandom_range(0, 9) == 0)
            bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         @(negedge clka);
         if (bus.redirect_valid) begin
            chk("rnd_mask", 32'(bus.inst_valid), 0);
            exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            idle = 0;
         end else if (bus.inst_valid && bus.inst_ready) begin
            chk("rnd_pc", bus.inst_pc, exp_pc);
            chk("rnd_inst", bus.inst, 32'(exp_pc[ADDR_W+1:2]));
            exp_pc = exp_pc + 32'd4;
            idle = 0;
         end else if (bus.inst_ready) begin
            idle++;
            if (idle > 4) begin
               tests++;
               fails++;
               $display("FAIL rnd_stall: %0d idle cycles, limit 4", idle);
               idle = 0;
            end
         end
         @(posedge clka); #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
